mpsram_port_ctrl: RTL
=====================

MPSRAM_PORT_CTRL -- requirements
Module: mpsram_port_ctrl

Interface
REQ-001 Parameters SHALL be:
  - NUM_W, 1: write ports
  - NUM_R, 1: read ports
  - W, 32: data width
  - N, 8: word count
  - INIT_VAL, '0: init pattern
  - A, derived localparam = $clog2(N)
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports, in order:
  - clk  in  1  clock
  - rst  in  1  asynchronous active-low reset
  - rd_req_vld  in  NUM_R  read request valid, per port
  - rd_req_addr  in  NUM_R*A  read address, port r at [r*A +: A]
  - rd_req_rdy  out  NUM_R  read request ready
  - rd_rsp_vld  out  NUM_R  read response valid
  - rd_rsp_data  out  NUM_R*W  read response data
  - rd_rsp_rdy  in  NUM_R  read response ready
  - wr_req_vld  in  NUM_W  write request valid
  - wr_req_addr  in  NUM_W*A  write address
  - wr_req_data  in  NUM_W*W  write data
  - wr_req_rdy  out  NUM_W  write request ready
  - mem_ren  out  NUM_R  memory read enable
  - mem_raddr  out  NUM_R*A  memory read address
  - mem_rdata  in  NUM_R*W  memory read data, valid exactly 1 cycle after mem_ren
  - mem_wen  out  NUM_W  memory write enable
  - mem_waddr  out  NUM_W*A  memory write address
  - mem_wdata  out  NUM_W*W  memory write data
  - init  in  1  init request, sampled every cycle
  - busy_w  out  1  init sequence in progress

Function
REQ-003 A handshake SHALL occur on a port in each cycle where both vld and rdy are 1.
REQ-004 The FSM SHALL have two states, IDLE and INIT, and SHALL reset to IDLE.
REQ-005 IDLE with init=1 SHALL go to INIT on the next edge, with the address counter set to 0.
REQ-006 In INIT, each cycle SHALL drive mem_wen[0]=1, mem_waddr[0]=counter, mem_wdata[0]=INIT_VAL, and mem_wen[NUM_W-1:1]=0, then increment the counter.
REQ-007 When counter==N-1 is written, the FSM SHALL return to IDLE on that edge; INIT SHALL last exactly N cycles.
REQ-008 busy_w SHALL be 1 exactly while in INIT (registered state decode, no combinational path from init).
REQ-009 init asserted while in INIT SHALL be ignored, with no restart.
REQ-010 In INIT, all wr_req_rdy and rd_req_rdy SHALL be 0.
REQ-011 In INIT, responses already buffered or in flight SHALL still complete and drain normally.
REQ-012 In IDLE, wr_req_rdy SHALL be all 1s.
REQ-013 In IDLE, mem_wen[w] SHALL equal wr_req_vld[w], with address and data passed through combinationally in the same cycle.
REQ-014 Write-write address collisions SHALL be passed to the memory unchanged; the block does no arbitration.
REQ-015 Each read port SHALL own a 3-entry response FIFO plus a 2-bit credit counter (in-flight + occupied), range 0..3.
REQ-016 rd_req_rdy[r] SHALL be 1 iff the FSM is IDLE and credit[r]<3; the ready path SHALL NOT depend combinationally on rd_rsp_rdy.
REQ-017 mem_ren[r] SHALL equal rd_req_vld[r] & rd_req_rdy[r], with mem_raddr passed through in the same cycle.
REQ-018 mem_rdata[r] SHALL be pushed into FIFO r on the edge ending the cycle after mem_ren[r].
REQ-019 Read latency SHALL be: request handshake at cycle T gives rd_rsp_vld at T+2 at the earliest.
REQ-020 rd_rsp_vld[r] SHALL be 1 iff FIFO r is non-empty, and rd_rsp_data SHALL be the FIFO head.
REQ-021 Data and valid SHALL hold stable until the response handshake.
REQ-022 Credit SHALL increment on a request handshake and decrement on a response handshake; when both occur in the same cycle it SHALL be unchanged.
REQ-023 The FIFO SHALL never overflow; the credit limit guarantees this.
REQ-024 Sustained throughput SHALL be 1 read per cycle per port when rd_rsp_rdy=1.
REQ-025 Responses SHALL return in request order per port; ports SHALL be fully independent.
REQ-026 Same-cycle read and write of one address SHALL NOT be forwarded; the result is defined by the memory.
REQ-027 FIFO pointers SHALL wrap modulo 3.

Reset
REQ-028 On rst=0, asynchronously and regardless of state, the block SHALL:
  - go to IDLE, counter=0
  - set credits=0 and all FIFOs empty
  - force busy_w=0 and rd_rsp_vld=0
REQ-029 While rst=0, all rd_req_rdy, wr_req_rdy, mem_ren and mem_wen SHALL be 0.
REQ-030 Reset during INIT SHALL abort the sequence; memory contents are then undefined, and no further init writes SHALL be issued.
REQ-031 After rst rises, the block SHALL accept requests on the first edge; no automatic init SHALL occur.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
  - Init: N=8, INIT_VAL=0, pulse init 1 cycle -> busy_w=1 for exactly 8 cycles; mem_waddr[0] 0..7; all rdy=0 throughout; then reads of addr 0..7 return 0.
  - Streaming: NUM_R=2, rd_rsp_rdy=1, port 0 reads addr 0..7 back-to-back -> 8 responses on consecutive cycles starting T+2, in order, data matching prior writes.
  - Backpressure: rd_rsp_rdy[0]=0, rd_req_vld[0]=1 held -> exactly 3 accepted, then rd_req_rdy[0]=0; release -> 3 responses in order, no loss.
  - Init collision: init asserted with 2 reads in flight -> both responses delivered during INIT; no new reads accepted until busy_w=0.
  - Reset mid-INIT: rst=0 at INIT cycle 4 -> busy_w=0 immediately, no mem_wen afterward, rd_rsp_vld=0; after release, a write then read of addr 3 returns the written value.

Source files
------------

// File: rtl/mpsram_port_ctrl.sv
// Multi-port SRAM port controller.
// Write ports pass straight through to the memory. Each read port has a
// 3-deep response FIFO with credit-based flow control. A one-shot INIT
// sequence writes INIT_VAL to every word through write port 0 while all
// request ports are held off.

// Per-read-port lane: credit counter, one-cycle memory latency tracker and
// a 3-entry response FIFO.
module mpsram_rd_lane #(
    parameter int W = 32,
    parameter int A = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         accept_en_i,
    input  logic         req_vld_i,
    input  logic [A-1:0] req_addr_i,
    output logic         req_rdy_o,
    output logic         rsp_vld_o,
    output logic [W-1:0] rsp_data_o,
    input  logic         rsp_rdy_i,
    output logic         mem_ren_o,
    output logic [A-1:0] mem_raddr_o,
    input  logic [W-1:0] mem_rdata_i
);
    logic [1:0]   credit_q, credit_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [1:0]   wptr_q, rptr_q;
    logic         pend_q;
    logic [W-1:0] fifo_q [3];
    logic         req_hs, push, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credits cover in-flight plus buffered reads, so the FIFO cannot overflow.
    assign req_rdy_o   = accept_en_i & (credit_q != 2'd3);
    assign req_hs      = req_vld_i & req_rdy_o;
    assign mem_ren_o   = req_hs;
    assign mem_raddr_o = req_addr_i;
    assign push        = pend_q;
    assign rsp_vld_o   = (cnt_q != 2'd0);
    assign rsp_data_o  = fifo_q[rptr_q];
    assign pop         = rsp_vld_o & rsp_rdy_i;

    // Credit and occupancy next-state; simultaneous inc/dec cancel out.
    always_comb begin
        credit_d = credit_q;
        cnt_d    = cnt_q;
        case ({req_hs, pop})
            2'b10:   credit_d = credit_q + 2'd1;
            2'b01:   credit_d = credit_q - 2'd1;
            default: credit_d = credit_q;
        endcase
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_q <= 2'd0;
            cnt_q    <= 2'd0;
            wptr_q   <= 2'd0;
            rptr_q   <= 2'd0;
            pend_q   <= 1'b0;
        end else begin
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            pend_q   <= req_hs;
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
        end
    end

    // FIFO storage captures memory data the cycle after the read enable.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= mem_rdata_i;
    end
endmodule

module mpsram_port_ctrl #(
    parameter int             NUM_W    = 1,
    parameter int             NUM_R    = 1,
    parameter int             W        = 32,
    parameter int             N        = 8,
    parameter logic [W-1:0]   INIT_VAL = '0,
    localparam int            A        = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_R-1:0]   rd_req_vld,
    input  logic [NUM_R*A-1:0] rd_req_addr,
    output logic [NUM_R-1:0]   rd_req_rdy,
    output logic [NUM_R-1:0]   rd_rsp_vld,
    output logic [NUM_R*W-1:0] rd_rsp_data,
    input  logic [NUM_R-1:0]   rd_rsp_rdy,
    input  logic [NUM_W-1:0]   wr_req_vld,
    input  logic [NUM_W*A-1:0] wr_req_addr,
    input  logic [NUM_W*W-1:0] wr_req_data,
    output logic [NUM_W-1:0]   wr_req_rdy,
    output logic [NUM_R-1:0]   mem_ren,
    output logic [NUM_R*A-1:0] mem_raddr,
    input  logic [NUM_R*W-1:0] mem_rdata,
    output logic [NUM_W-1:0]   mem_wen,
    output logic [NUM_W*A-1:0] mem_waddr,
    output logic [NUM_W*W-1:0] mem_wdata,
    input  logic               init,
    output logic               busy_w
);
    typedef enum logic {ST_IDLE, ST_INIT} state_t;

    state_t       state_q, state_d;
    logic [A-1:0] cnt_q, cnt_d;
    logic         accept_en;

    // Requests are accepted only in IDLE and never while reset is held.
    assign busy_w    = (state_q == ST_INIT);
    assign accept_en = rst & (state_q == ST_IDLE);

    // FSM next state; init is ignored once the sequence is running.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            ST_INIT: begin
                if (cnt_q == A'(N - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + A'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register; reset aborts any running init sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write path: pass-through in IDLE, port 0 owned by the init sweep in INIT.
    always_comb begin
        mem_wen    = '0;
        mem_waddr  = wr_req_addr;
        mem_wdata  = wr_req_data;
        wr_req_rdy = '0;
        if (busy_w) begin
            mem_wen[0]      = 1'b1;
            mem_waddr[0+:A] = cnt_q;
            mem_wdata[0+:W] = INIT_VAL;
        end else if (accept_en) begin
            wr_req_rdy = '1;
            mem_wen    = wr_req_vld;
        end
    end

    for (genvar r = 0; r < NUM_R; r++) begin : g_rd
        mpsram_rd_lane #(.W(W), .A(A)) u_lane (
            .clk         (clk),
            .rst         (rst),
            .accept_en_i (accept_en),
            .req_vld_i   (rd_req_vld[r]),
            .req_addr_i  (rd_req_addr[r*A +: A]),
            .req_rdy_o   (rd_req_rdy[r]),
            .rsp_vld_o   (rd_rsp_vld[r]),
            .rsp_data_o  (rd_rsp_data[r*W +: W]),
            .rsp_rdy_i   (rd_rsp_rdy[r]),
            .mem_ren_o   (mem_ren[r]),
            .mem_raddr_o (mem_raddr[r*A +: A]),
            .mem_rdata_i (mem_rdata[r*W +: W])
        );
    end
endmodule
